// File: rtl/mult_control_unit.sv
// rtl/mult_control_unit.sv - sequencing FSM for the signed shift-add multiplier datapath
module mult_control_unit #(
   parameter int WIDTH = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_XA,
   output logic Ld_B,
   output logic Add_En,
   output logic Sub_En,
   output logic Shift_En,
   output logic Busy,
   output logic Done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           run_q;

   logic clr_d, ld_d, add_d, sub_d, shift_d, busy_d, done_d;

   // run_q resets high so a Run held through reset is not seen as a rising edge
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         run_q <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         run_q <= Run;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_d     = 1'b0;
      ld_d      = 1'b0;
      add_d     = 1'b0;
      sub_d     = 1'b0;
      shift_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state)
         IDLE: begin
            if (Run && !run_q) begin
               state_nxt = CLR;
            end else begin
               clr_d = ClearA_LoadB;
               ld_d  = ClearA_LoadB;
            end
         end
         CLR: begin
            clr_d     = 1'b1;
            busy_d    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ADD;
         end
         ADD: begin
            // the sign bit of the multiplier carries negative weight
            busy_d    = 1'b1;
            add_d     = M && (cnt != LAST);
            sub_d     = M && (cnt == LAST);
            state_nxt = SHIFT;
         end
         SHIFT: begin
            shift_d = 1'b1;
            busy_d  = 1'b1;
            if (cnt == LAST) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt   = cnt + CW'(1);
               state_nxt = ADD;
            end
         end
         DONE: begin
            done_d    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // strobes are masked while Reset is asserted so a mid-operation reset emits nothing
   assign Clr_XA   = clr_d   & ~Reset;
   assign Ld_B     = ld_d    & ~Reset;
   assign Add_En   = add_d   & ~Reset;
   assign Sub_En   = sub_d   & ~Reset;
   assign Shift_En = shift_d & ~Reset;
   assign Busy     = busy_d  & ~Reset;
   assign Done     = done_d  & ~Reset;

endmodule

// File: tb/tb_mult_control_unit.sv
// tb/tb_mult_control_unit.sv - directed self-checking bench for mult_control_unit
module tb_mult_control_unit;

   logic Clk, Reset, Run, ClearA_LoadB, M;
   logic Clr_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done;

   logic       use_dp, m_force;
   logic [7:0] S, A, B;
   logic       X;
   logic [8:0] sum;

   int passed = 0;
   int total  = 0;

   mult_control_unit #(.WIDTH(8)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
      .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Add_En(Add_En), .Sub_En(Sub_En),
      .Shift_En(Shift_En), .Busy(Busy), .Done(Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign M = use_dp ? B[0] : m_force;

   // behavioural X:A:B datapath
   always_comb begin
      if (Sub_En) sum = {X, A} - {S[7], S};
      else        sum = {X, A} + {S[7], S};
   end

   always_ff @(posedge Clk) begin
      if (Clr_XA) begin
         X <= 1'b0;
         A <= 8'h00;
      end
      if (Ld_B) B <= S;
      if (Add_En || Sub_En) begin
         X <= sum[8];
         A <= sum[7:0];
      end
      if (Shift_En) begin
         A <= {X, A[7:1]};
         B <= {A[0], B[7:1]};
      end
   end

   task automatic next();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_clr"}, Clr_XA, 1'b0);
      chk({tag, "_ld"}, Ld_B, 1'b0);
      chk({tag, "_add"}, Add_En, 1'b0);
      chk({tag, "_sub"}, Sub_En, 1'b0);
      chk({tag, "_shift"}, Shift_En, 1'b0);
      chk({tag, "_busy"}, Busy, 1'b0);
      chk({tag, "_done"}, Done, 1'b0);
   endtask

   // open-loop timing check with M tied to mval; Run edge sampled at edge t
   task automatic pattern(input logic mval);
      m_force = mval;
      use_dp  = 1'b0;
      Run     = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         next();
         if (k == 2) Run = 1'b0;
         chk($sformatf("p%0d_clr_k%0d", mval, k), Clr_XA, k == 1);
         chk($sformatf("p%0d_add_k%0d", mval, k), Add_En,
             mval && (k % 2 == 0) && k >= 2 && k <= 14);
         chk($sformatf("p%0d_sub_k%0d", mval, k), Sub_En, mval && k == 16);
         chk($sformatf("p%0d_shift_k%0d", mval, k), Shift_En, (k % 2 == 1) && k >= 3 && k <= 17);
         chk($sformatf("p%0d_busy_k%0d", mval, k), Busy, k >= 1 && k <= 17);
         chk($sformatf("p%0d_done_k%0d", mval, k), Done, k == 18);
      end
   endtask

   task automatic run_mult(input string tag, input logic [15:0] exp);
      bit seen = 0;
      Run = 1'b1;
      next();
      Run = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (Done) begin
            seen = 1;
            break;
         end
         next();
      end
      chk({tag, "_done_seen"}, Done, 1'b1);
      if (seen) chk16({tag, "_AB"}, {A, B}, exp);
      next();
   endtask

   task automatic load_and_mult(input string tag, input logic [7:0] bval,
                                input logic [7:0] sval, input logic [15:0] exp);
      use_dp       = 1'b1;
      S            = bval;
      ClearA_LoadB = 1'b1;
      next();
      ClearA_LoadB = 1'b0;
      S            = sval;
      run_mult(tag, exp);
   endtask

   initial begin
      Reset = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b0;
      use_dp = 1'b0; m_force = 1'b0; S = 8'h00;
      next();
      next();
      chk_all_zero("in_reset");

      // Run held through reset deassert must not start
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         next();
         chk($sformatf("held_run_busy%0d", k), Busy, 1'b0);
         chk($sformatf("held_run_clr%0d", k), Clr_XA, 1'b0);
      end
      chk_all_zero("after_reset");
      Run = 1'b0;
      next();
      Run = 1'b1;
      next();
      chk("repress_clr", Clr_XA, 1'b1);
      chk("repress_busy", Busy, 1'b1);
      Run = 1'b0;
      for (int k = 0; k < 18; k++) next();
      chk("repress_idle", Busy, 1'b0);

      // ClearA_LoadB level in IDLE
      ClearA_LoadB = 1'b1;
      #1;
      chk("calb_ld", Ld_B, 1'b1);
      chk("calb_clr", Clr_XA, 1'b1);
      next();
      chk("calb_ld_held", Ld_B, 1'b1);
      ClearA_LoadB = 1'b0;
      #1;
      chk("calb_ld_rel", Ld_B, 1'b0);

      pattern(1'b0);
      pattern(1'b1);

      load_and_mult("p12x9", 8'h09, 8'h0C, 16'h006C);
      load_and_mult("p12xm9", 8'hF7, 8'h0C, 16'hFF94);
      load_and_mult("m12x9", 8'h09, 8'hF4, 16'hFF94);
      load_and_mult("m12xm9", 8'hF7, 8'hF4, 16'h006C);

      load_and_mult("cons1", 8'hFF, 8'hFF, 16'h0001);
      run_mult("cons2", 16'hFFFF);
      run_mult("cons3", 16'h0001);

      // abuse while busy: ClearA_LoadB and Run re-press are ignored
      use_dp = 1'b0; m_force = 1'b0;
      Run = 1'b1;
      next();
      Run = 1'b0;
      for (int k = 2; k <= 22; k++) begin
         next();
         if (k == 4) ClearA_LoadB = 1'b1;
         if (k == 6) begin ClearA_LoadB = 1'b0; Run = 1'b1; end
         if (k == 8) Run = 1'b0;
         if (k == 10) Run = 1'b1;
         #1;
         if (k >= 4 && k <= 10) begin
            chk($sformatf("busy_ld_k%0d", k), Ld_B, 1'b0);
            chk($sformatf("busy_clr_k%0d", k), Clr_XA, 1'b0);
         end
         if (k == 18) chk("abuse_done", Done, 1'b1);
         if (k >= 19) begin
            chk($sformatf("no_restart_busy_k%0d", k), Busy, 1'b0);
            chk($sformatf("no_restart_clr_k%0d", k), Clr_XA, 1'b0);
         end
      end
      Run = 1'b0;
      next();

      // Run edge and ClearA_LoadB together in IDLE
      Run = 1'b1; ClearA_LoadB = 1'b1;
      #1;
      chk("same_ld_idle", Ld_B, 1'b0);
      chk("same_clr_idle", Clr_XA, 1'b0);
      next();
      chk("same_clr_state", Clr_XA, 1'b1);
      chk("same_ld_state", Ld_B, 1'b0);
      Run = 1'b0; ClearA_LoadB = 1'b0;
      for (int k = 0; k < 18; k++) next();

      // reset mid-operation at t+8
      Run = 1'b1;
      next();
      Run = 1'b0;
      for (int k = 2; k <= 8; k++) next();
      Reset = 1'b1;
      #1;
      chk_all_zero("rst_t8");
      next();
      Reset = 1'b0;
      #1;
      chk_all_zero("rst_t9");
      for (int k = 10; k <= 22; k++) begin
         next();
         chk($sformatf("rst_done_k%0d", k), Done, 1'b0);
         chk($sformatf("rst_shift_k%0d", k), Shift_En, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
